// File: rtl/ahb_rr_burst_arbiter_pkg.sv
// Shared AHB types plus the arbiter's FSM encoding and burst-length decode.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package ahb_rr_burst_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_type;

   typedef enum logic [2:0] {
      SINGLE = 3'd0,
      INCR   = 3'd1,
      WRAP4  = 3'd2,
      INCR4  = 3'd3,
      WRAP8  = 3'd4,
      INCR8  = 3'd5,
      WRAP16 = 3'd6,
      INCR16 = 3'd7
   } hburst_type;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ADDR,
      ARB_BURST
   } arb_state_e;

   localparam int BEAT_CNT_W = 4;

   // Index of the final beat of a fixed-length burst (beats numbered from 0).
   // INCR returns 0 here; its unbounded nature is tracked by a separate flag.
   function automatic logic [BEAT_CNT_W-1:0] burst_limit(input hburst_type b);
      logic [BEAT_CNT_W-1:0] lim;
      case (b)
         WRAP4,  INCR4  : lim = 4'd3;
         WRAP8,  INCR8  : lim = 4'd7;
         WRAP16, INCR16 : lim = 4'd15;
         default        : lim = 4'd0;
      endcase
      return lim;
   endfunction

endpackage

// File: rtl/ahb_rr_burst_arbiter_if.sv
// Bus bundle between the requesting masters (pre-muxed burst/trans, slave wait)
// and one per-slave arbiter. master = request side, slave = arbiter side.
// Signals: hreq/hburst/htrans/hwait toward the arbiter; hgrant/hsel/hmaster/hlast back.
interface ahb_rr_burst_arbiter_if #(
   parameter int MASTER_NUM = 4,
   parameter int MIDX_W     = $clog2(MASTER_NUM)
) ();
   import ahb_rr_burst_arbiter_pkg::*;

   logic [MASTER_NUM-1:0] hreq;
   hburst_type            hburst;
   htrans_type            htrans;
   logic                  hwait;
   logic [MASTER_NUM-1:0] hgrant;
   logic                  hsel;
   logic [MIDX_W-1:0]     hmaster;
   logic                  hlast;

   modport master (
      output hreq, hburst, htrans, hwait,
      input  hgrant, hsel, hmaster, hlast
   );

   modport slave (
      input  hreq, hburst, htrans, hwait,
      output hgrant, hsel, hmaster, hlast
   );
endinterface

// File: rtl/ahb_rr_pick.sv
// Rotating priority pick: first requester at or after ptr+1 (mod MASTER_NUM).
// Latency: purely combinational.
// Backpressure: none; pick is all-zero when no request is present.
// Ports: req (per-master request), ptr (last served index), pick (one-hot), idx.
module ahb_rr_pick #(
   parameter int MASTER_NUM = 4,
   parameter int MIDX_W     = $clog2(MASTER_NUM)
) (
   input  logic [MASTER_NUM-1:0] req,
   input  logic [MIDX_W-1:0]     ptr,
   output logic [MASTER_NUM-1:0] pick,
   output logic [MIDX_W-1:0]     idx
);

   logic              found;
   logic [MIDX_W-1:0] cand;

   always_comb begin
      pick  = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      // Walk ptr+1 .. ptr+MASTER_NUM so the last served master is tried last.
      for (int i = 1; i <= MASTER_NUM; i++) begin
         cand = MIDX_W'((int'(ptr) + i) % MASTER_NUM);
         if (!found && req[cand]) begin
            found     = 1'b1;
            pick[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/ahb_rr_burst_arbiter.sv
// Per-slave round-robin arbiter holding each grant for one whole AHB burst.
// Latency: grant registered one cycle after request; zero dead cycles on handover.
// Backpressure: hwait=1 freezes state, beat count and grant.
// Ports: hclk, hreset_n, arb_if (slave modport: hreq/hburst/htrans/hwait in,
//        hgrant/hsel/hmaster registered-or-derived out, hlast combinational out).
module ahb_rr_burst_arbiter #(
   parameter int MASTER_NUM = 4,
   parameter int MIDX_W     = $clog2(MASTER_NUM)
) (
   input  logic                 hclk,
   input  logic                 hreset_n,
   ahb_rr_burst_arbiter_if.slave arb_if
);
   import ahb_rr_burst_arbiter_pkg::*;

   arb_state_e              state_q;
   logic [MASTER_NUM-1:0]   hgrant_q;
   logic [MIDX_W-1:0]       hmaster_q;
   logic [MIDX_W-1:0]       ptr_q;
   logic [BEAT_CNT_W-1:0]   count_q;
   logic [BEAT_CNT_W-1:0]   limit_q;
   logic                    incr_q;

   logic [MASTER_NUM-1:0]   pick;
   logic [MIDX_W-1:0]       pick_idx;
   logic [MIDX_W-1:0]       pick_ptr;
   logic                    hsel;
   logic                    gnt_req;
   logic                    any_req;
   logic                    beat_ok;
   logic                    first_beat;
   logic                    addr_drop;
   logic                    beat_last;
   logic                    count_en;
   logic                    retire;

   assign hsel    = |hgrant_q;
   assign gnt_req = |(arb_if.hreq & hgrant_q);
   assign any_req = |arb_if.hreq;

   // In idle the rotation starts from the stored ptr; on a retire it starts from
   // the retiring master, which is the value ptr takes at the same edge.
   assign pick_ptr = (state_q == ARB_IDLE) ? ptr_q : hmaster_q;

   ahb_rr_pick #(
      .MASTER_NUM (MASTER_NUM),
      .MIDX_W     (MIDX_W)
   ) u_pick (
      .req  (arb_if.hreq),
      .ptr  (pick_ptr),
      .pick (pick),
      .idx  (pick_idx)
   );

   always_comb begin
      beat_ok    = hsel & ~arb_if.hwait &
                   ((arb_if.htrans == NONSEQ) | (arb_if.htrans == SEQ));
      first_beat = 1'b0;
      addr_drop  = 1'b0;
      beat_last  = 1'b0;
      count_en   = 1'b0;
      case (state_q)
         ARB_ADDR: begin
            first_beat = beat_ok & (arb_if.htrans == NONSEQ);
            // Owner gave up before issuing anything: release without a beat,
            // so no hlast is raised for it.
            addr_drop  = ~arb_if.hwait & ~first_beat & ~gnt_req;
            if (first_beat) begin
               beat_last = (arb_if.hburst == INCR) ? ~gnt_req
                                                   : (burst_limit(arb_if.hburst) == '0);
            end
         end
         ARB_BURST: begin
            if (beat_ok) begin
               if (incr_q) begin
                  // A fresh NONSEQ ends an undefined-length burst as well.
                  beat_last = (arb_if.htrans == NONSEQ) | ~gnt_req;
               end else begin
                  beat_last = (arb_if.htrans == SEQ) && ((count_q + 4'd1) == limit_q);
               end
               count_en = (arb_if.htrans == SEQ) & ~beat_last & (count_q != 4'hF);
            end
         end
         default: ;
      endcase
      retire = beat_last | addr_drop;
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state_q   <= ARB_IDLE;
         hgrant_q  <= '0;
         hmaster_q <= '0;
         ptr_q     <= MIDX_W'(MASTER_NUM - 1);
         count_q   <= '0;
         limit_q   <= '0;
         incr_q    <= 1'b0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (any_req) begin
                  hgrant_q  <= pick;
                  hmaster_q <= pick_idx;
                  state_q   <= ARB_ADDR;
               end
            end
            ARB_ADDR, ARB_BURST: begin
               if (retire) begin
                  ptr_q   <= hmaster_q;
                  count_q <= '0;
                  if (any_req) begin
                     hgrant_q  <= pick;
                     hmaster_q <= pick_idx;
                     state_q   <= ARB_ADDR;
                  end else begin
                     hgrant_q <= '0;
                     state_q  <= ARB_IDLE;
                  end
               end else if (first_beat) begin
                  limit_q <= burst_limit(arb_if.hburst);
                  incr_q  <= (arb_if.hburst == INCR);
                  count_q <= '0;
                  state_q <= ARB_BURST;
               end else if (count_en) begin
                  count_q <= count_q + 4'd1;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign arb_if.hgrant  = hgrant_q;
   assign arb_if.hsel    = hsel;
   assign arb_if.hmaster = hmaster_q;
   assign arb_if.hlast   = beat_last;

endmodule

// File: doc/ahb_rr_burst_arbiter.md
# ahb_rr_burst_arbiter

Per-slave round-robin arbiter for the AHB interconnect. It shares one slave port between MASTER_NUM masters and holds each grant for exactly one complete burst. It counts accepted beats against the burst length latched from hburst, and rotates priority only when a burst retires. It sits in front of each slave mux, in the same position as the generated per-slave arbiters, and drives the slave-side hsel and master-select.

## Interface
- MASTER_NUM, default 4: number of requesting masters (2..16).
- MIDX_W, default $clog2(MASTER_NUM): width of the master index.
- hclk, input, 1: clock, rising edge.
- hreset_n, input, 1: reset, asynchronous, active-low.
- hreq, input, MASTER_NUM: per-master request, level, held until the burst is done.
- hburst, input, hburst_type: burst type of the currently granted master (pre-muxed).
- htrans, input, htrans_type: transfer type of the currently granted master (pre-muxed).
- hwait, input, 1: slave wait; 1 = current beat not accepted.
- hgrant, output, MASTER_NUM: one-hot registered grant.
- hsel, output, 1: |hgrant.
- hmaster, output, MIDX_W: index of the granted master; valid when hsel=1.
- hlast, output, 1: combinational; 1 in the cycle the final beat of the burst is accepted.

## Operation
- Beat accepted = hsel & ~hwait & (htrans==NONSEQ | htrans==SEQ). IDLE and BUSY never count.
- FSM states are ARB_IDLE, ARB_ADDR and ARB_BURST.
- ARB_IDLE:
  - hgrant=0.
  - If |hreq, the rotating pick selects the first requester at or after ptr+1 (mod MASTER_NUM). The grant is registered, and the FSM moves to ARB_ADDR.
- ARB_ADDR: waits for the first accepted NONSEQ beat.
  - On that beat, latch the limit: SINGLE→0; INCR4/WRAP4→3; INCR8/WRAP8→7; INCR16/WRAP16→15; INCR→unbounded flag.
  - Clear count.
  - If limit=0, retire; otherwise go to ARB_BURST.
  - If the granted hreq drops before any beat, retire without counting.
- ARB_BURST: count (4 bits) increments on each accepted SEQ beat.
  - Fixed bursts: last = accepted beat with count==limit. count never wraps past limit.
  - INCR: last = accepted beat in a cycle where the granted hreq=0. An accepted NONSEQ while in ARB_BURST during INCR also retires the burst; that NONSEQ beat is not counted for the next owner.
- Retire:
  - hlast=1 for that cycle, and ptr←hmaster.
  - If any hreq is pending (including the retiring master), pick again in the same cycle with the updated rotation and go to ARB_ADDR. Otherwise go to ARB_IDLE.
- hwait=1 freezes count, state and grant. Grant never changes while hwait=1.
- Requests from non-granted masters never preempt an active burst.

## Timing
- Reset values: hgrant=0, hsel=0, hmaster=0, hlast=0, state=ARB_IDLE, count=0, ptr=MASTER_NUM-1 (master 0 wins first).
- Request latency: hreq rising before edge n gives hgrant at edge n (one cycle after it is sampled in ARB_IDLE).
- Handover: last beat accepted at edge k, so the new hgrant is valid after edge k. There is zero dead cycles between back-to-back bursts.
- Simultaneous retire and new requests: requests sampled in the retire cycle participate, using the updated ptr.
- Reset asserted mid-burst: all outputs return to reset values asynchronously. The burst is abandoned, with no hlast.
- hlast depends combinationally on hwait and htrans. The only combinational outputs are hlast and hsel.

## Structure
- AHB_package: hburst_type and htrans_type (existing). Add arb_state_e {ARB_IDLE, ARB_ADDR, ARB_BURST} and the function burst_limit(hburst_type) returning 4 bits.
- Sub-module ahb_rr_pick (combinational): inputs req and ptr, outputs one-hot pick and index. It is parameterised by MASTER_NUM and reusable by other arbiters.
- Top: FSM, beat counter, limit/INCR-flag registers, and the ptr register.

## Test plan
- Reset, then hreq=4'b0001 with SINGLE NONSEQ accepted → hgrant=0001 one cycle later; hlast=1 on the first beat; return to ARB_IDLE; ptr=0.
- hreq=4'b1111 continuously, all INCR4, hwait=0 → grants rotate 0,1,2,3,0; each grant lasts exactly 4 accepted beats plus 1 address-wait cycle at first grant; no idle cycle between bursts.
- Master 2 runs INCR8 with hwait=1 inserted on beats 3 and 6 → count holds during waits; hlast on the 8th accepted beat; hgrant constant for 10 cycles of beats.
- Master 1 runs INCR (undefined length) and drops hreq after 5 beats while master 3 requests → retire on the beat accepted with hreq1=0; hgrant=1000 the next cycle.
- Master 0 is granted but drops hreq before any NONSEQ → released with no counted beats; pending master 1 granted the next cycle.
- hreset_n pulsed low during beat 2 of WRAP16 → hgrant=0 and hsel=0 immediately; after release, the first grant goes to the lowest requester via ptr=MASTER_NUM-1.
